// File: rtl/fpu_issue_pkg.sv
// Shared types and constants for the FPU issue sequencer.
//   - fpu_issue_state_e : sequencer FSM states
//   - fpu_req_t         : one queued request (opcode, rounding mode, operands, tag)
//   - FPUOP_*           : opcode values used by callers and the bench
//   - is_cmp_op()       : selects which FPU valid completes an op
// The request struct fields are sized by the REQ_* constants below. The top
// level's OP_W/RM_W/TAG_W parameters must keep the same values.
package fpu_issue_pkg;

    localparam int REQ_OP_W  = 8;
    localparam int REQ_RM_W  = 2;
    localparam int REQ_TAG_W = 4;

    localparam logic [REQ_OP_W-1:0] FPUOP_ADD  = 8'h00;
    localparam logic [REQ_OP_W-1:0] FPUOP_SUB  = 8'h01;
    localparam logic [REQ_OP_W-1:0] FPUOP_MUL  = 8'h02;
    localparam logic [REQ_OP_W-1:0] FPUOP_DIV  = 8'h03;
    localparam logic [REQ_OP_W-1:0] FPUOP_SFEQ = 8'h08;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        WAIT,
        RESP,
        FLUSH
    } fpu_issue_state_e;

    typedef struct packed {
        logic [REQ_OP_W-1:0]  op;
        logic [REQ_RM_W-1:0]  rm;
        logic [31:0]          a;
        logic [31:0]          b;
        logic [REQ_TAG_W-1:0] tag;
    } fpu_req_t;

    // Compare opcodes (sfeq, sfne, ...) all have bit 3 set; they finish on
    // the FPU compare valid instead of the arithmetic valid.
    function automatic logic is_cmp_op(input logic [REQ_OP_W-1:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/fpu_issue_fifo.sv
// Synchronous request FIFO for the FPU issue sequencer.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset (empties the FIFO)
//   push, wdata    write a request; ignored while full
//   pop            drop the head entry; ignored while empty
//   rdata          current head entry (valid when !empty)
//   full, empty    registered-count status flags
// DEPTH must be a power of two so that the pointers wrap naturally.
module fpu_issue_fifo
    import fpu_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  fpu_req_t wdata,
    input  logic     pop,
    output fpu_req_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    fpu_req_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer in front of the mor1kx FPU. Requests are queued in a small
// FIFO and sent to the FPU one at a time using its decode/execute/flush
// protocol. The sequencer then waits for the matching valid, or for a timeout,
// and returns a tagged response.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   req_*                        request valid/ready plus opcode, rm, operands, tag
//   abort                        drop the in-flight op (DECODE/EXEC/WAIT only)
//   fpu_flush/decode/execute     registered one-cycle strobes to the FPU
//   fpu_op/rm/opa/opb            held operands of the in-flight op
//   fpu_out, fpu_valid_arith,
//   fpu_cmp, fpu_valid_cmp,
//   fpu_fpcsr                    FPU results and flags
//   rsp_*                        response valid/ready plus captured payload
//   busy                         FSM active or requests still queued
//   perf_*                       saturating performance counters
// Build option: define FPU_ISSUE_PERF_EN to build the perf counters. Without
// it the perf ports are tied to zero.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a queued request; pops the head when one exists
// DECODE | fpu_decode high for this cycle
// EXEC   | fpu_execute high for this cycle; the timeout counter loads
// WAIT   | waiting for the matching FPU valid or the timeout
// RESP   | rsp_valid high, payload held until rsp_ready
// FLUSH  | fpu_flush high for this cycle, then back to IDLE
module fpu_issue_ctrl
    import fpu_issue_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int OP_W       = 8,
    parameter int RM_W       = 2,
    parameter int FPCSR_W    = 12,
    parameter int TAG_W      = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [OP_W-1:0]    req_op,
    input  logic [RM_W-1:0]    req_rm,
    input  logic [31:0]        req_a,
    input  logic [31:0]        req_b,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic               abort,
    output logic               fpu_flush,
    output logic               fpu_decode,
    output logic               fpu_execute,
    output logic [OP_W-1:0]    fpu_op,
    output logic [RM_W-1:0]    fpu_rm,
    output logic [31:0]        fpu_opa,
    output logic [31:0]        fpu_opb,
    input  logic [31:0]        fpu_out,
    input  logic               fpu_valid_arith,
    input  logic               fpu_cmp,
    input  logic               fpu_valid_cmp,
    input  logic [FPCSR_W-1:0] fpu_fpcsr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_result,
    output logic               rsp_cmp,
    output logic [FPCSR_W-1:0] rsp_flags,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               rsp_timeout,
    output logic               busy,
    output logic [31:0]        perf_issued,
    output logic [31:0]        perf_timeouts,
    output logic [31:0]        perf_wait_cycles
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // The counter counts down from TIMEOUT-1, so it reaches zero in WAIT
    // cycle number TIMEOUT.
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(TIMEOUT - 1);

    fpu_issue_state_e state;
    fpu_issue_state_e next_state;

    fpu_req_t         push_req;
    fpu_req_t         head_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    logic [TAG_W-1:0] tag_q;
    logic             is_cmp_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             op_hit;
    logic             capture;
    logic             timed_out;

    assign push_req  = '{op: req_op, rm: req_rm, a: req_a, b: req_b, tag: req_tag};
    assign req_ready = !fifo_full;

    fpu_issue_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (req_valid && req_ready),
        .wdata   (push_req),
        .pop     (pop),
        .rdata   (head_req),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Only the valid that matches the op type completes it. The other valid
    // is ignored.
    assign op_hit    = is_cmp_q ? fpu_valid_cmp : fpu_valid_arith;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE) || !fifo_empty;

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        capture    = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: next_state = abort ? FLUSH : EXEC;
            EXEC:   next_state = abort ? FLUSH : WAIT;
            WAIT: begin
                if (abort) begin
                    next_state = FLUSH;
                end else if (op_hit) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end else if (wait_cnt == '0) begin
                    capture    = 1'b1;
                    timed_out  = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = FLUSH;
                end
            end
            FLUSH:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            fpu_decode  <= 1'b0;
            fpu_execute <= 1'b0;
            fpu_flush   <= 1'b0;
            fpu_op      <= '0;
            fpu_rm      <= '0;
            fpu_opa     <= '0;
            fpu_opb     <= '0;
            tag_q       <= '0;
            is_cmp_q    <= 1'b0;
            wait_cnt    <= '0;
            rsp_result  <= '0;
            rsp_cmp     <= 1'b0;
            rsp_flags   <= '0;
            rsp_tag     <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= next_state;
            fpu_decode  <= (next_state == DECODE);
            fpu_execute <= (next_state == EXEC);
            fpu_flush   <= (next_state == FLUSH);

            if (pop) begin
                fpu_op   <= head_req.op;
                fpu_rm   <= head_req.rm;
                fpu_opa  <= head_req.a;
                fpu_opb  <= head_req.b;
                tag_q    <= head_req.tag;
                is_cmp_q <= is_cmp_op(head_req.op);
            end

            if (state == EXEC) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end

            if (capture) begin
                rsp_tag     <= tag_q;
                rsp_timeout <= timed_out;
                if (timed_out) begin
                    rsp_result <= '0;
                    rsp_cmp    <= 1'b0;
                    rsp_flags  <= '0;
                end else if (is_cmp_q) begin
                    rsp_result <= '0;
                    rsp_cmp    <= fpu_cmp;
                    rsp_flags  <= fpu_fpcsr;
                end else begin
                    rsp_result <= fpu_out;
                    rsp_cmp    <= 1'b0;
                    rsp_flags  <= fpu_fpcsr;
                end
            end
        end
    end

`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] issued_q;
    logic [31:0] timeouts_q;
    logic [31:0] wait_cycles_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            issued_q      <= '0;
            timeouts_q    <= '0;
            wait_cycles_q <= '0;
        end else begin
            if ((state == IDLE) && (next_state == DECODE) && (issued_q != '1)) begin
                issued_q <= issued_q + 32'd1;
            end
            if (timed_out && (timeouts_q != '1)) begin
                timeouts_q <= timeouts_q + 32'd1;
            end
            if ((state == WAIT) && (wait_cycles_q != '1)) begin
                wait_cycles_q <= wait_cycles_q + 32'd1;
            end
        end
    end

    assign perf_issued      = issued_q;
    assign perf_timeouts    = timeouts_q;
    assign perf_wait_cycles = wait_cycles_q;
`else
    assign perf_issued      = '0;
    assign perf_timeouts    = '0;
    assign perf_wait_cycles = '0;
`endif

endmodule
